// File: rtl/sdbp_frame_tx.sv
// Backlight frame port: captures one refresh worth of brightness words into a
// double-buffered frame RAM and shifts the completed frame MSB-first to the drivers.
//
// state  | meaning
// S_IDLE | serializer stopped, sclk/le low, waiting for a bank swap
// S_LOAD | two-cycle fetch of front[idx] into the shift register
// S_SHIFT| 16 bits out, each CLK_DIV low then CLK_DIV high on sclk
// S_LATCH| sdbp_le high for LE_CYCLES, then frame_done
module sdbp_frame_tx #(
    parameter int N_LED     = 360,
    parameter int DW        = 16,
    parameter int AW        = 10,
    parameter int CLK_DIV   = 2,
    parameter int LE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sdbpflag,
    input  logic [AW-1:0] wtaddr,
    input  logic [DW-1:0] wtdina,
    output logic          sdbp_sclk,
    output logic          sdbp_sdo,
    output logic          sdbp_le,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_drop
);
    localparam int IW = $clog2(N_LED);
    localparam int BW = $clog2(DW);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int LW = $clog2(LE_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;
    state_t state, state_nx;

    logic [DW-1:0] bank [2][N_LED];
    logic [DW-1:0] rd_data;
    logic [DW-1:0] shreg;
    logic [AW-1:0] addr_d;
    logic [IW-1:0] idx;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] div_cnt;
    logic [LW-1:0] le_cnt;
    logic          flag_d, cap, sel, pending, start_q;
    logic          hi, ld_ph;
    logic          wr_en, cap_end, ser_free, latch_last, swap, pend_nx, drop_nx;
    logic          div_tc, bit_last, idx_last, le_tc;
    logic          sclk_c, sdo_c, le_c;

    // capture: writer data trails its address by one clk, so addr_d lines up with wtdina
    assign wr_en   = cap && (addr_d < AW'(N_LED));
    assign cap_end = wr_en && (addr_d == AW'(N_LED - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_d <= 1'b0;
            addr_d <= '0;
            cap    <= 1'b0;
        end else begin
            flag_d <= sdbpflag;
            addr_d <= wtaddr;
            if (cap_end)
                cap <= 1'b0;
            else if (sdbpflag && !flag_d)
                cap <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            bank[~sel][addr_d[IW-1:0]] <= wtdina;
        rd_data <= bank[sel][idx];
    end

    // bank hand-off; latch_last counts as free so a pending frame follows with one idle cycle
    assign latch_last = (state == S_LATCH) && le_tc;
    assign ser_free   = ((state == S_IDLE) && !start_q) || latch_last;

    always_comb begin
        swap    = 1'b0;
        pend_nx = pending;
        drop_nx = 1'b0;
        if (cap_end) begin
            if (ser_free) begin
                swap    = 1'b1;
                pend_nx = 1'b0;
                drop_nx = pending;
            end else if (!pending) begin
                pend_nx = 1'b1;
            end else begin
                drop_nx = 1'b1;
            end
        end else if (ser_free && pending && !cap) begin
            swap    = 1'b1;
            pend_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            pending    <= 1'b0;
            start_q    <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            sel        <= sel ^ swap;
            pending    <= pend_nx;
            start_q    <= swap;
            frame_drop <= drop_nx;
        end
    end

    assign div_tc   = (div_cnt == '0);
    assign bit_last = (bit_cnt == BW'(DW - 1));
    assign idx_last = (idx == IW'(N_LED - 1));
    assign le_tc    = (le_cnt == '0);

    always_comb begin
        state_nx = state;
        sclk_c   = 1'b0;
        sdo_c    = 1'b0;
        le_c     = 1'b0;
        case (state)
            S_IDLE:  if (start_q) state_nx = S_LOAD;
            S_LOAD:  if (ld_ph) state_nx = S_SHIFT;
            S_SHIFT: begin
                sclk_c = hi;
                sdo_c  = shreg[DW-1];
                if (hi && div_tc && bit_last)
                    state_nx = idx_last ? S_LATCH : S_LOAD;
            end
            S_LATCH: begin
                le_c = 1'b1;
                if (le_tc) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign sdbp_sclk = sclk_c;
    assign sdbp_sdo  = sdo_c;
    assign sdbp_le   = le_c;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            le_cnt     <= '0;
            hi         <= 1'b0;
            ld_ph      <= 1'b0;
            shreg      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= latch_last;
            case (state)
                S_IDLE: begin
                    idx   <= '0;
                    ld_ph <= 1'b0;
                end
                S_LOAD: begin
                    ld_ph <= ~ld_ph;
                    if (ld_ph) begin
                        shreg   <= rd_data;
                        bit_cnt <= '0;
                        hi      <= 1'b0;
                        div_cnt <= CW'(CLK_DIV - 1);
                    end
                end
                S_SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= CW'(CLK_DIV - 1);
                        hi      <= ~hi;
                        if (hi) begin
                            shreg <= shreg << 1;
                            if (bit_last) begin
                                le_cnt <= LW'(LE_CYCLES - 1);
                                if (!idx_last) idx <= idx + 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                S_LATCH: if (!le_tc) le_cnt <= le_cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdbp_frame_tx.sv
// Directed bench for sdbp_frame_tx: capture, serial timing, pending/drop handling, reset abort.
module tb_sdbp_frame_tx;
    localparam int N_LED     = 360;
    localparam int DW        = 16;
    localparam int AW        = 10;
    localparam int CLK_DIV   = 2;
    localparam int LE_CYCLES = 4;
    localparam int WORD_T    = 2 + 32 * CLK_DIV;
    localparam int FRAME_T   = N_LED * WORD_T + LE_CYCLES + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sdbpflag = 1'b0;
    logic [AW-1:0] wtaddr = '0;
    logic [DW-1:0] wtdina = '0;
    logic          sdbp_sclk, sdbp_sdo, sdbp_le, busy, frame_done, frame_drop;

    sdbp_frame_tx #(.N_LED(N_LED), .DW(DW), .AW(AW), .CLK_DIV(CLK_DIV), .LE_CYCLES(LE_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .sdbpflag(sdbpflag), .wtaddr(wtaddr), .wtdina(wtdina),
        .sdbp_sclk(sdbp_sclk), .sdbp_sdo(sdbp_sdo), .sdbp_le(sdbp_le), .busy(busy),
        .frame_done(frame_done), .frame_drop(frame_drop)
    );

    always #20 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int kind, input int i);
        case (kind)
            0:       return DW'(32'hA500 + i);
            1:       return DW'(32'h5B00 ^ (i * 3));
            2:       return DW'(32'h3C00 + i * 7);
            default: return DW'(32'hD0F0 ^ i);
        endcase
    endfunction

    // ---------------- monitor ----------------
    int            slot = -1;
    int            nrise [3];
    int            le_len [3];
    int            busy_cyc [3];
    int            first_rise_cyc [3];
    int            done_cyc [3];
    logic [DW-1:0] rx [3][N_LED];
    logic [DW-1:0] wacc = '0;
    int            stab_err = 0, idle_sdo_err = 0, drop_cnt = 0, done_cnt = 0, post_rst_busy = 0;
    logic          sclk_p = 1'b0, sclk_pp = 1'b0, sdo_p = 1'b0, sdo_pp = 1'b0, busy_p = 1'b0;
    logic          watch_idle = 1'b0;

    always @(negedge clk) begin
        sclk_p  <= sdbp_sclk;
        sclk_pp <= sclk_p;
        sdo_p   <= sdbp_sdo;
        sdo_pp  <= sdo_p;
        busy_p  <= busy;
        if (busy && !busy_p) begin
            slot <= slot + 1;
            if (slot + 1 < 3) begin
                busy_cyc[slot+1]       <= cyc;
                nrise[slot+1]          <= 0;
                le_len[slot+1]         <= 0;
                first_rise_cyc[slot+1] <= -1;
            end
        end else if (slot >= 0 && slot < 3) begin
            if (sdbp_sclk && !sclk_p) begin
                if (sclk_pp || sdbp_sdo != sdo_p || sdo_p != sdo_pp) stab_err <= stab_err + 1;
                wacc <= {wacc[DW-2:0], sdbp_sdo};
                if (nrise[slot] % DW == DW - 1 && nrise[slot] / DW < N_LED)
                    rx[slot][nrise[slot] / DW] <= {wacc[DW-2:0], sdbp_sdo};
                if (nrise[slot] == 0) first_rise_cyc[slot] <= cyc;
                nrise[slot] <= nrise[slot] + 1;
            end
            if (sdbp_sclk && sclk_p && sdbp_sdo != sdo_p) stab_err <= stab_err + 1;
            if (sdbp_le) le_len[slot] <= le_len[slot] + 1;
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            if (slot >= 0 && slot < 3) done_cyc[slot] <= cyc;
        end
        if (frame_drop) drop_cnt <= drop_cnt + 1;
        if (!busy && sdbp_sdo) idle_sdo_err <= idle_sdo_err + 1;
        if (watch_idle && busy) post_rst_busy <= post_rst_busy + 1;
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic          flag;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_busy;
        logic          exp_sclk;
        logic          exp_sdo;
        logic          exp_le;
    } vec_t;
    vec_t stray [8];

    // writer timing: address at step i, its data one clk later; returns the capture-end cycle
    task automatic write_frame(input int kind, output int ce);
        ce = 0;
        for (int i = 0; i <= N_LED; i++) begin
            @(posedge clk); #1;
            if (i == 0) sdbpflag = 1'b1;
            wtaddr = (i < N_LED) ? AW'(i) : AW'(N_LED);
            wtdina = (i > 0) ? word(kind, i - 1) : '0;
            if (i == N_LED) ce = cyc;
        end
        @(posedge clk); #1;
        sdbpflag = 1'b0;
        wtaddr   = '0;
    endtask

    task automatic apply_stray(input bit chk);
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1;
            sdbpflag = stray[r].flag;
            wtaddr   = stray[r].addr;
            wtdina   = stray[r].data;
            @(negedge clk);
            if (chk) begin
                check($sformatf("stray%0d busy", r), int'(busy), int'(stray[r].exp_busy));
                check($sformatf("stray%0d sclk", r), int'(sdbp_sclk), int'(stray[r].exp_sclk));
                check($sformatf("stray%0d sdo", r), int'(sdbp_sdo), int'(stray[r].exp_sdo));
                check($sformatf("stray%0d le", r), int'(sdbp_le), int'(stray[r].exp_le));
            end
        end
        @(posedge clk); #1;
        wtaddr = '0;
        wtdina = '0;
    endtask

    task automatic check_outputs_low(input string tag);
        check({tag, " sclk"}, int'(sdbp_sclk), 0);
        check({tag, " sdo"}, int'(sdbp_sdo), 0);
        check({tag, " le"}, int'(sdbp_le), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " frame_done"}, int'(frame_done), 0);
        check({tag, " frame_drop"}, int'(frame_drop), 0);
    endtask

    initial begin
        int ce_a, ce_b, ce_c, ce_d, n, err;

        stray[0] = '{1'b0, 10'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        stray[1] = '{1'b0, 10'd1,    16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        stray[2] = '{1'b0, 10'd2,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        stray[3] = '{1'b0, 10'd5,    16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        stray[4] = '{1'b0, 10'd359,  16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0};
        stray[5] = '{1'b0, 10'd360,  16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0};
        stray[6] = '{1'b0, 10'd512,  16'h8001, 1'b0, 1'b0, 1'b0, 1'b0};
        stray[7] = '{1'b0, 10'd1023, 16'h7FFE, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 check_outputs_low("reset");
        rst_n = 1'b1;

        // idle writes with no flag edge: nothing may start
        apply_stray(1'b1);
        repeat (10) @(posedge clk);
        check("idle no start", slot, -1);

        // frame A
        write_frame(0, ce_a);
        n = 0;
        while (slot < 0 && n < 20) begin @(negedge clk); n++; end
        check("frameA started", int'(slot >= 0), 1);
        check("frameA busy latency", busy_cyc[0] - ce_a, 2);
        repeat (10) @(negedge clk);
        check("frameA first sclk rise", first_rise_cyc[0] - busy_cyc[0], 2 + CLK_DIV);

        // B becomes pending, C overwrites it
        repeat (1000) @(posedge clk);
        write_frame(1, ce_b);
        repeat (5) @(posedge clk);
        check("no drop after B", drop_cnt, 0);
        repeat (200) @(posedge clk);
        write_frame(2, ce_c);
        repeat (5) @(posedge clk);
        check("one drop after C", drop_cnt, 1);
        apply_stray(1'b0);

        n = 0;
        while (done_cnt < 1 && n < FRAME_T + 1000) begin @(negedge clk); n++; end
        check("frameA done seen", done_cnt, 1);
        check("frameA done from capture-end", done_cyc[0] - ce_a, FRAME_T + 1);
        check("frameA sclk rises", nrise[0], N_LED * DW);
        check("frameA le width", le_len[0], LE_CYCLES);
        check("frameA word0", int'(rx[0][0]), 16'hA500);
        check("frameA word359", int'(rx[0][N_LED-1]), int'(word(0, N_LED - 1)));
        err = 0;
        for (int i = 0; i < N_LED; i++) if (rx[0][i] !== word(0, i)) err++;
        check("frameA word errors", err, 0);

        n = 0;
        while (slot < 1 && n < 20) begin @(negedge clk); n++; end
        check("frame2 started", int'(slot >= 1), 1);
        check("frame2 one idle cycle", busy_cyc[1] - done_cyc[0], 1);

        // reset in the middle of word 100 of the second frame
        n = 0;
        while (nrise[1] < 100 * DW + 5 && n < 100 * WORD_T + 200) begin @(negedge clk); n++; end
        check("frame2 reached word100", int'(nrise[1] >= 100 * DW + 5), 1);
        @(posedge clk); #5;
        rst_n = 1'b0;
        #1 check_outputs_low("mid-frame reset");
        check("frame2 word0 is capture C", int'(rx[1][0]), int'(word(2, 0)));
        err = 0;
        for (int i = 0; i < 100; i++) if (rx[1][i] !== word(2, i)) err++;
        check("frame2 word errors", err, 0);
        check("frame2 no latch", le_len[1], 0);
        check("drop count unchanged", drop_cnt, 1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        watch_idle = 1'b1;
        repeat (300) @(posedge clk);
        write_frame(3, ce_d);
        #1 watch_idle = 1'b0;
        check("no output after reset until capture", post_rst_busy, 0);

        n = 0;
        while (slot < 2 && n < 20) begin @(negedge clk); n++; end
        check("frameD started", int'(slot >= 2), 1);
        check("frameD busy latency", busy_cyc[2] - ce_d, 2);
        n = 0;
        while (nrise[2] < 2 * DW && n < 3 * WORD_T) begin @(negedge clk); n++; end
        check("frameD word0", int'(rx[2][0]), int'(word(3, 0)));
        check("frameD word1", int'(rx[2][1]), int'(word(3, 1)));

        check("sdo/sclk stability errors", stab_err, 0);
        check("sdo nonzero while idle", idle_sdo_err, 0);
        check("total frame_done pulses", done_cnt, 1);
        check("total frame_drop pulses", drop_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
